norm_row_arbiter: RTL and testbench
===================================

// Module: norm_row_arbiter
// PURPOSE
//  Shares one 128-bit AXI-Stream norm datapath (delay-line/variance path) between N_REQ
//  requester streams. Arbitration is row-granular and round-robin: one requester owns the
//  datapath for a whole row of cfg_row_beats beats. Each beat carries its owner ID in TUSER,
//  and the last beat of the row carries TLAST, so the downstream demux can route results.
// PARAMETERS
//  N_REQ    2    number of requester streams (2..8)
//  DATA_W   128  beat width in bits
//  CNT_W    16   width of the row-length / beat counter
//  ID_W     $clog2(N_REQ) (min 1)  width of TUSER / grant ID
// PORTS
//  aclk           in   1             clock
//  arstn          in   1             asynchronous reset, active low
//  cfg_row_beats  in   CNT_W         beats per row; sampled at grant
//  pause          in   1             blocks new grants; does not stop a row in progress
//  S_AXIS_TDATA   in   N_REQ*DATA_W  requester data, flattened; req i at [i*DATA_W +: DATA_W]
//  S_AXIS_TVALID  in   N_REQ         per-requester valid
//  S_AXIS_TREADY  out  N_REQ         per-requester ready
//  M_AXIS_TDATA   out  DATA_W        data to norm datapath
//  M_AXIS_TVALID  out  1             valid to datapath
//  M_AXIS_TREADY  in   1             ready from datapath
//  M_AXIS_TUSER   out  ID_W          owner ID of current beat
//  M_AXIS_TLAST   out  1             last beat of row
//  busy           out  1             high while in GRANT state
//  row_done       out  1             1-cycle pulse after last beat of a row is accepted
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, row_len=0. All outputs 0.
//   Reset has effect mid-row: the row is abandoned and no TLAST is emitted.
//  FSM: 2 states.
//   IDLE: if !pause and |S_AXIS_TVALID, choose the first valid requester scanning from
//    rr_ptr upward with wrap-around. Register grant_id. Latch
//    row_len = (cfg_row_beats==0) ? 1 : cfg_row_beats. Clear beat_cnt. Go to GRANT.
//    No data handshake happens in IDLE: all S_AXIS_TREADY=0 and M_AXIS_TVALID=0.
//   GRANT: combinational pass-through of the granted requester only.
//    - M_AXIS_TVALID = S_AXIS_TVALID[grant_id].
//    - M_AXIS_TDATA = slice[grant_id].
//    - S_AXIS_TREADY[grant_id] = M_AXIS_TREADY; all other TREADY bits = 0.
//    - M_AXIS_TUSER = grant_id.
//    - M_AXIS_TLAST = (beat_cnt == row_len-1).
//    On each handshake (M_AXIS_TVALID & M_AXIS_TREADY), beat_cnt increments.
//    On the handshake of the last beat: go to IDLE, rr_ptr = (grant_id+1) mod N_REQ,
//    row_done=1 on the next cycle.
//  Latency: 0 cycles data path (combinational) in GRANT. The datapath gets exactly one
//   idle cycle (IDLE) between consecutive rows. First beat can be accepted 1 cycle after
//   the request is seen.
//  Handshake: in GRANT, the owner dropping TVALID stalls the row; ownership is kept and
//   no other requester is granted. M_AXIS_TDATA/TUSER/TLAST stay stable while
//   TVALID=1 and TREADY=0.
//  cfg_row_beats changes mid-row have no effect until the next grant.
//  pause in GRANT: ignored until the row ends; the block then stays in IDLE while pause=1.
//  Simultaneous requests: round-robin from rr_ptr. A lone requester is re-granted
//   back-to-back (rr_ptr wraps to it).
//  beat_cnt is CNT_W wide and cannot overflow because row_len <= 2^CNT_W-1.
//  busy = (state==GRANT). row_done is registered.
// STRUCTURE
//  Shared package norm_pkg:
//   - NORM_DATA_W=128
//   - state encoding localparams ST_IDLE/ST_GRANT
//   - function clog2_min1
//  Sub-module norm_rr_pick (N_REQ, ID_W): combinational round-robin picker.
//   Inputs: req vector, rr_ptr. Outputs: any, pick_id.
//  Top: FSM, beat counter, row_len register, data mux, TREADY decode.
// TESTING
//  1. N_REQ=2, row=4, only req0 valid, M ready=1 -> 4 beats TUSER=0, TLAST on beat 4,
//     row_done 1 cycle later, 1 idle cycle, then req0 re-granted.
//  2. Both valid continuously, row=3 -> rows alternate 0,1,0,1. Each row is 3 beats with
//     TLAST on the 3rd. TREADY of the non-owner is always 0.
//  3. Owner drops TVALID for 2 cycles mid-row while req1 is valid -> no switch. Row resumes
//     and completes with 4 beats. req1 is granted next.
//  4. M_AXIS_TREADY=0 for 3 cycles on beat 2 -> TDATA/TUSER/TLAST stable, beat_cnt frozen,
//     S_AXIS_TREADY[owner]=0.
//  5. cfg_row_beats=0 -> 1-beat rows with TLAST=1. cfg changed 4->2 mid-row -> current row
//     still 4 beats, next row 2.
//  6. pause=1 asserted mid-row -> row finishes, then no grant until pause=0. Reset
//     asserted on beat 2 -> all outputs 0 immediately, rr_ptr=0 after release.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared definitions for the row-granular norm datapath arbiter.
package norm_pkg;

    localparam int unsigned NORM_DATA_W = 128;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } norm_state_e;

    // A 1-bit ID is still needed when there is only one requester.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/norm_row_arbiter_if.sv
// AXI-Stream bundle: N_REQ requester streams in, one owner-tagged stream out to the datapath.
interface norm_row_arbiter_if
    import norm_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = NORM_DATA_W,
    parameter int unsigned ID_W   = clog2_min1(N_REQ)
);

    logic [N_REQ*DATA_W-1:0] S_AXIS_TDATA;
    logic [N_REQ-1:0]        S_AXIS_TVALID;
    logic [N_REQ-1:0]        S_AXIS_TREADY;
    logic [DATA_W-1:0]       M_AXIS_TDATA;
    logic                    M_AXIS_TVALID;
    logic                    M_AXIS_TREADY;
    logic [ID_W-1:0]         M_AXIS_TUSER;
    logic                    M_AXIS_TLAST;

    // Environment side: requesters and the downstream datapath.
    modport master (
        output S_AXIS_TDATA,
        output S_AXIS_TVALID,
        input  S_AXIS_TREADY,
        input  M_AXIS_TDATA,
        input  M_AXIS_TVALID,
        output M_AXIS_TREADY,
        input  M_AXIS_TUSER,
        input  M_AXIS_TLAST
    );

    // Arbiter side.
    modport slave (
        input  S_AXIS_TDATA,
        input  S_AXIS_TVALID,
        output S_AXIS_TREADY,
        output M_AXIS_TDATA,
        output M_AXIS_TVALID,
        input  M_AXIS_TREADY,
        output M_AXIS_TUSER,
        output M_AXIS_TLAST
    );

endinterface

// File: rtl/norm_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, with wrap.
module norm_rr_pick
    import norm_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  rr_ptr_i,
    output logic             any_o,
    output logic [ID_W-1:0]  pick_id_o
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest candidate back to rr_ptr so the closest one wins last.
    always_comb begin
        any_o     = 1'b0;
        pick_id_o = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr_i) + k) % N_REQ);
            if (req_i[idx]) begin
                any_o     = 1'b1;
                pick_id_o = idx;
            end
        end
    end

endmodule

// File: rtl/norm_row_arbiter.sv
// Row-granular round-robin arbiter sharing one AXI-Stream norm datapath among N_REQ streams.
module norm_row_arbiter
    import norm_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = NORM_DATA_W,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ID_W   = clog2_min1(N_REQ)
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [CNT_W-1:0] cfg_row_beats,
    input  logic             pause,
    norm_row_arbiter_if.slave axis,
    output logic             busy,
    output logic             row_done
);

    norm_state_e     state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] row_len_q, row_len_d;
    logic            row_done_q, row_done_d;

    logic            pick_any;
    logic [ID_W-1:0] pick_id;
    logic            in_grant;
    logic            owner_valid;
    logic            hs;
    logic            last_beat;

    norm_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i     (axis.S_AXIS_TVALID),
        .rr_ptr_i  (rr_ptr_q),
        .any_o     (pick_any),
        .pick_id_o (pick_id)
    );

    assign in_grant    = (state_q == ST_GRANT);
    assign owner_valid = axis.S_AXIS_TVALID[grant_id_q];
    assign hs          = in_grant & owner_valid & axis.M_AXIS_TREADY;
    assign last_beat   = (beat_cnt_q == row_len_q - CNT_W'(1));

    // Pass-through of the owner only; everything is held at zero outside GRANT.
    always_comb begin
        axis.M_AXIS_TVALID = 1'b0;
        axis.M_AXIS_TDATA  = '0;
        axis.M_AXIS_TUSER  = '0;
        axis.M_AXIS_TLAST  = 1'b0;
        axis.S_AXIS_TREADY = '0;
        if (in_grant) begin
            axis.M_AXIS_TVALID = owner_valid;
            axis.M_AXIS_TDATA  = axis.S_AXIS_TDATA[grant_id_q*DATA_W +: DATA_W];
            axis.M_AXIS_TUSER  = grant_id_q;
            axis.M_AXIS_TLAST  = last_beat;
            for (int i = 0; i < N_REQ; i++) begin
                axis.S_AXIS_TREADY[i] = (grant_id_q == ID_W'(i)) & axis.M_AXIS_TREADY;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        row_len_d  = row_len_q;
        row_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!pause && pick_any) begin
                    grant_id_d = pick_id;
                    row_len_d  = (cfg_row_beats == '0) ? CNT_W'(1) : cfg_row_beats;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0
                                                                      : grant_id_q + ID_W'(1);
                        row_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            row_len_q  <= '0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            row_len_q  <= row_len_d;
            row_done_q <= row_done_d;
        end
    end

    assign busy     = in_grant;
    assign row_done = row_done_q;

endmodule

// File: tb/tb_norm_row_arbiter.sv
// Directed bench for norm_row_arbiter with N_REQ=2: row ownership, stalls, config and reset.
module tb_norm_row_arbiter;

    localparam logic [127:0] D0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] D1 = 128'hB1B1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;

    logic        aclk;
    logic        arstn;
    logic [15:0] cfg_row_beats;
    logic        pause;
    logic        busy;
    logic        row_done;

    int checks = 0;
    int errors = 0;

    norm_row_arbiter_if #(.N_REQ(2), .DATA_W(128), .ID_W(1)) axis ();

    norm_row_arbiter #(
        .N_REQ  (2),
        .DATA_W (128),
        .CNT_W  (16),
        .ID_W   (1)
    ) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .cfg_row_beats (cfg_row_beats),
        .pause         (pause),
        .axis          (axis),
        .busy          (busy),
        .row_done      (row_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge aclk);
        #1;
    endtask

    // Entered at a sample point inside GRANT at beat 'start'; leaves one cycle past the IDLE gap.
    task automatic expect_row(input int id, input int n, input int start);
        for (int b = start; b < n; b++) begin
            chk($sformatf("busy r%0d b%0d", id, b), busy, 1);
            chk($sformatf("tuser r%0d b%0d", id, b), axis.M_AXIS_TUSER, id);
            chk($sformatf("tvalid r%0d b%0d", id, b), axis.M_AXIS_TVALID, 1);
            chk($sformatf("tlast r%0d b%0d", id, b), axis.M_AXIS_TLAST, (b == n - 1));
            chk($sformatf("s_tready r%0d b%0d", id, b), axis.S_AXIS_TREADY, (id == 0) ? 1 : 2);
            chk($sformatf("tdata r%0d b%0d", id, b), axis.M_AXIS_TDATA, (id == 0) ? D0 : D1);
            if (b == start) chk($sformatf("row_done_low r%0d", id), row_done, 0);
            cyc();
        end
        chk($sformatf("row_done r%0d", id), row_done, 1);
        chk($sformatf("gap_busy r%0d", id), busy, 0);
        chk($sformatf("gap_tvalid r%0d", id), axis.M_AXIS_TVALID, 0);
        chk($sformatf("gap_tready r%0d", id), axis.S_AXIS_TREADY, 0);
        cyc();
    endtask

    initial begin
        arstn              = 1'b0;
        cfg_row_beats      = 16'd4;
        pause              = 1'b0;
        axis.S_AXIS_TDATA  = {D1, D0};
        axis.S_AXIS_TVALID = 2'b00;
        axis.M_AXIS_TREADY = 1'b0;
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_tvalid", axis.M_AXIS_TVALID, 0);
        chk("rst_tlast", axis.M_AXIS_TLAST, 0);
        chk("rst_tdata", axis.M_AXIS_TDATA, 0);
        chk("rst_s_tready", axis.S_AXIS_TREADY, 0);

        // Lone requester 0, 4-beat rows, re-granted after one idle cycle.
        arstn              = 1'b1;
        axis.S_AXIS_TVALID = 2'b01;
        axis.M_AXIS_TREADY = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_tvalid", axis.M_AXIS_TVALID, 0);
        chk("idle_s_tready", axis.S_AXIS_TREADY, 0);
        cyc();
        expect_row(0, 4, 0);

        // Both valid: alternate owners; cfg changes only land at the next grant.
        axis.S_AXIS_TVALID = 2'b11;
        cfg_row_beats      = 16'd3;
        #1;
        expect_row(0, 4, 0);
        expect_row(1, 3, 0);
        expect_row(0, 3, 0);
        cfg_row_beats = 16'd4;
        #1;
        expect_row(1, 3, 0);

        // Owner 0 drops TVALID for two cycles while req1 waits: ownership is kept.
        chk("t3_tuser_b0", axis.M_AXIS_TUSER, 0);
        cyc();
        axis.S_AXIS_TVALID = 2'b10;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t3_tvalid_gap%0d", k), axis.M_AXIS_TVALID, 0);
            chk($sformatf("t3_busy_gap%0d", k), busy, 1);
            chk($sformatf("t3_tuser_gap%0d", k), axis.M_AXIS_TUSER, 0);
            chk($sformatf("t3_s_tready_gap%0d", k), axis.S_AXIS_TREADY, 1);
            cyc();
        end
        axis.S_AXIS_TVALID = 2'b11;
        #1;
        expect_row(0, 4, 1);

        // Downstream backpressure on beat 2 of req1's row.
        chk("t4_tuser_b0", axis.M_AXIS_TUSER, 1);
        cyc();
        axis.M_AXIS_TREADY = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_tvalid_st%0d", k), axis.M_AXIS_TVALID, 1);
            chk($sformatf("t4_tuser_st%0d", k), axis.M_AXIS_TUSER, 1);
            chk($sformatf("t4_tlast_st%0d", k), axis.M_AXIS_TLAST, 0);
            chk($sformatf("t4_tdata_st%0d", k), axis.M_AXIS_TDATA, D1);
            chk($sformatf("t4_s_tready_st%0d", k), axis.S_AXIS_TREADY, 0);
            cyc();
        end
        axis.M_AXIS_TREADY = 1'b1;
        #1;
        expect_row(1, 4, 1);

        // Zero length means one beat; mid-row cfg edits wait for the next grant.
        cfg_row_beats = 16'd0;
        #1;
        expect_row(0, 4, 0);
        expect_row(1, 1, 0);
        cfg_row_beats = 16'd4;
        #1;
        expect_row(0, 1, 0);
        cfg_row_beats = 16'd2;
        #1;
        expect_row(1, 4, 0);
        expect_row(0, 2, 0);

        // Pause mid-row: the row completes, then no grant until pause drops.
        pause = 1'b1;
        #1;
        expect_row(1, 2, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_pause_busy%0d", k), busy, 0);
            chk($sformatf("t6_pause_tvalid%0d", k), axis.M_AXIS_TVALID, 0);
            chk($sformatf("t6_pause_row_done%0d", k), row_done, 0);
            cyc();
        end
        pause = 1'b0;
        #1;
        chk("t6_unpause_idle", busy, 0);
        cyc();
        expect_row(0, 2, 0);

        // Reset on beat 2 of req1's row (rr_ptr is 1 here): outputs drop, rr_ptr returns to 0.
        chk("t6_tuser_b0", axis.M_AXIS_TUSER, 1);
        cyc();
        arstn = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tvalid", axis.M_AXIS_TVALID, 0);
        chk("t6_rst_tlast", axis.M_AXIS_TLAST, 0);
        chk("t6_rst_tuser", axis.M_AXIS_TUSER, 0);
        chk("t6_rst_tdata", axis.M_AXIS_TDATA, 0);
        chk("t6_rst_s_tready", axis.S_AXIS_TREADY, 0);
        cyc();
        chk("t6_rst_row_done", row_done, 0);
        arstn = 1'b1;
        #1;
        chk("t6_release_idle", busy, 0);
        cyc();
        expect_row(0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
